sklansky_subtractor_pipe: RTL and testbench
===========================================

Name: sklansky_subtractor_pipe

Overview:
- Pipelined, flow-controlled subtractor: y = a - b - bin over SIZE bits.
- Internally computes a + ~b + ~bin on a Sklansky parallel-prefix carry network; borrow-out = ~carry-out.
- Two register stages with valid/ready handshakes at both ends, so it can sit between streaming producers and consumers in the datapath, under backpressure.
- Counterpart to the team's registered-output Sklansky adder: subtract direction, registered inputs and outputs, full flow control.

Parameters:
- SIZE, 32, operand/result width in bits (>= 2).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer presents a, b, bin.
- in_ready  output  1  block accepts this cycle.
- a  input  SIZE  minuend.
- b  input  SIZE  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts this cycle.
- y  output  SIZE  difference, mod 2^SIZE unless saturation is compiled in.
- bout  output  1  unsigned borrow-out.
- zero  output  1  y == 0.
- ovf  output  1  signed overflow of a - b - bin.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid = 0, s2_valid = 0.
  - All data registers = 0.
  - Outputs: out_valid = 0, y = 0, bout = 0, zero = 0, ovf = 0.
  - in_ready = 1 while in reset and immediately after.
- Stage 1 (operand register):
  - Captures a, b and bin on an input transfer (in_valid & in_ready).
  - s1_valid set on transfer; cleared when stage 1 moves to stage 2 with no new input arriving.
- Stage 2 (result register):
  - Captures the prefix-adder result and flags from stage 1 when s2_load = s1_valid & (!s2_valid | out_ready).
  - Drives y, bout, zero and ovf directly from registers; no combinational path from a or b to any output.
- Handshake rules:
  - in_ready = !s1_valid | !s2_valid | out_ready.
  - This is combinational from out_ready. That path is permitted; no other combinational input-to-output paths exist.
  - While out_valid & !out_ready, y, bout, zero and ovf stay stable.
  - out_valid never drops without a transfer.
- Latency and throughput:
  - Latency: an input transfer on cycle N gives out_valid on cycle N+2 if the output is unblocked.
  - Throughput: 1 result per cycle with out_ready held high.
  - No bubbles are inserted.
- Ordering and capacity:
  - Results leave in acceptance order.
  - Capacity is 2 transactions.
  - With out_ready low, the block fills both stages and then deasserts in_ready.
- Simultaneous events:
  - An input transfer and a stage-1-to-stage-2 move in the same cycle: stage 1 takes the new operands and s1_valid stays 1.
  - An output transfer and a stage-2 load in the same cycle: stage 2 takes the new result and s2_valid stays 1.
- Arithmetic:
  - {c, y} = a + ~b + !bin, computed at SIZE+1 bits.
  - bout = !c, i.e. bout = 1 iff unsigned a < b + bin.
  - ovf = (a[SIZE-1] != b[SIZE-1]) & (y[SIZE-1] != a[SIZE-1]), using the wrapped y.
  - zero is evaluated on the final y (after saturation, if enabled).
- Reset mid-operation: all in-flight transactions are discarded; no partial output is produced.
- in_valid while in_ready = 0:
  - Producer must hold its data.
  - The block does not sample it.

Optional Feature:
- Macro: SKLANSKY_SUB_SAT_EN.
- Defined: signed saturation.
  - When ovf = 1, y is clamped to the signed maximum (0x7FFF_FFFF for SIZE=32) if a is non-negative, else the signed minimum (0x8000_0000).
  - ovf and bout still report the unsaturated condition.
  - zero is taken from the clamped y.
- Not defined: y wraps modulo 2^SIZE; no clamp logic is synthesized.

Test Plan:
- Basic and borrow-in: a=10, b=3, bin=0 -> y=7, bout=0, zero=0, ovf=0, two cycles after the transfer; a=5, b=5, bin=1 -> y=0xFFFF_FFFF, bout=1, zero=0.
- Zero flag: a=0x1234_5678, b=0x1234_5678, bin=0 -> y=0, zero=1, bout=0.
- Overflow:
  - a=0x8000_0000, b=1 -> ovf=1, bout=0.
  - Wrap build: y=0x7FFF_FFFF.
  - Build with SKLANSKY_SUB_SAT_EN: y=0x8000_0000.
  - a=0x7FFF_FFFF, b=0xFFFF_FFFF -> ovf=1; sat build y=0x7FFF_FFFF.
- Backpressure:
  - Hold out_ready=0 and stream 3 operand pairs.
  - Required: in_ready low after 2 accepts; y held stable.
  - Release out_ready: results emerge in order with no loss or duplication.
- Throughput: 100 random back-to-back transfers with out_ready=1 -> one result per cycle, each matching a scoreboard of (a-b-bin) mod 2^32 with correct flags.
- Reset mid-stream: assert rst_n low with both stages full -> out_valid=0 and y=0 asynchronously; after release, first new input gives its result at N+2 and nothing stale appears.

Source files
------------

// File: rtl/sklansky_subtractor_pipe.sv
// Two-stage flow-controlled subtractor y = a - b - bin on a Sklansky prefix network.
// Define SKLANSKY_SUB_SAT_EN to clamp y to the signed range on overflow.
module sklansky_subtractor_pipe #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] y,
  output logic            bout,
  output logic            zero,
  output logic            ovf
);

  localparam int L = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic            r_s1_valid;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic            r_bin;

  logic            r_s2_valid;
  logic [SIZE-1:0] r_y;
  logic            r_bout;
  logic            r_zero;
  logic            r_ovf;

  logic            w_in_xfer;
  logic            w_s2_load;

  assign in_ready  = !r_s1_valid | !r_s2_valid | out_ready;
  assign w_in_xfer = in_valid & in_ready;
  assign w_s2_load = r_s1_valid & (!r_s2_valid | out_ready);

  // a + ~b + !bin; the carry-in is folded into bit 0's generate
  logic [SIZE-1:0] w_bn;
  logic            w_cin;
  logic [SIZE-1:0] w_g0;
  logic [SIZE-1:0] w_p0;
  logic [SIZE-1:0] w_g [0:L];
  logic [SIZE-1:0] w_p [0:L];

  assign w_bn   = ~r_b;
  assign w_cin  = ~r_bin;
  assign w_g0   = r_a & w_bn;
  assign w_p0   = r_a ^ w_bn;
  assign w_g[0] = {w_g0[SIZE-1:1], w_g0[0] | (w_p0[0] & w_cin)};
  assign w_p[0] = w_p0;

  for (genvar l = 0; l < L; l++) begin : g_lvl
    for (genvar i = 0; i < SIZE; i++) begin : g_bit
      if (((i >> l) & 1) == 1) begin : g_op
        localparam int J = ((i >> l) << l) - 1;
        assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][J]);
        assign w_p[l+1][i] = w_p[l][i] & w_p[l][J];
      end else begin : g_pass
        assign w_g[l+1][i] = w_g[l][i];
        assign w_p[l+1][i] = w_p[l][i];
      end
    end
  end

  logic            w_unused_p;
  logic [SIZE:0]   w_c;
  logic [SIZE-1:0] w_y;
  logic            w_cout;
  logic            w_ovf;
  logic [SIZE-1:0] w_y_fin;

  assign w_unused_p = ^w_p[L];
  assign w_c        = {w_g[L], w_cin};
  assign w_y        = w_p0 ^ w_c[SIZE-1:0];
  assign w_cout     = w_c[SIZE];
  assign w_ovf      = (r_a[SIZE-1] != r_b[SIZE-1]) &
                      (w_y[SIZE-1] != r_a[SIZE-1]);

`ifdef SKLANSKY_SUB_SAT_EN
  localparam logic [SIZE-1:0] SMAX = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] SMIN = {1'b1, {(SIZE-1){1'b0}}};

  always_comb begin
    w_y_fin = w_y;
    if (w_ovf) w_y_fin = r_a[SIZE-1] ? SMIN : SMAX;
  end
`else
  assign w_y_fin = w_y;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_bin      <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_s1_valid <= 1'b1;
        r_a        <= a;
        r_b        <= b;
        r_bin      <= bin;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
      r_bout     <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_y        <= w_y_fin;
        r_bout     <= ~w_cout;
        r_zero     <= (w_y_fin == '0);
        r_ovf      <= w_ovf;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign y         = r_y;
  assign bout      = r_bout;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_sklansky_subtractor_pipe.sv
// Directed and random checks for sklansky_subtractor_pipe (SIZE=32).
// Build with SKLANSKY_SUB_SAT_EN defined to check the saturating variant.
module tb_sklansky_subtractor_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        bout;
  logic        zero;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  sklansky_subtractor_pipe #(.SIZE(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {ovf, zero, bout, y} from the arithmetic definition
  function automatic logic [34:0] model(input logic [31:0] ma,
                                        input logic [31:0] mb,
                                        input logic mbin);
    logic [32:0] d;
    logic [31:0] r;
    logic        o;
    d = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
    r = d[31:0];
    o = (ma[31] != mb[31]) && (r[31] != ma[31]);
`ifdef SKLANSKY_SUB_SAT_EN
    if (o) r = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {o, (r == 32'd0), d[32], r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [34:0] outs();
    return {ovf, zero, bout, y};
  endfunction

  // one transfer with out_ready high; checks N+1 empty, N+2 result
  task automatic run1(input string tag, input logic [31:0] ta,
                      input logic [31:0] tb, input logic tbin,
                      input logic [34:0] exp);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    bin = tbin;
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk(tag, 64'(outs()), 64'(exp));
    tick();
  endtask

  logic [34:0] q[$];
  logic [34:0] e0, e1, e2;
  logic [34:0] hold;
  logic [31:0] ra, rb;
  logic        rbin;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    bin = 1'b0;
    #2;
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(outs()), 64'd0);
    chk("rst_ir", 64'(in_ready), 64'd1);
    #20;
    rst_n = 1'b1;
    tick();
    chk("post_ir", 64'(in_ready), 64'd1);

    run1("basic", 32'd10, 32'd3, 1'b0, {1'b0, 1'b0, 1'b0, 32'd7});
    run1("bin", 32'd5, 32'd5, 1'b1, {1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF});
    run1("zero", 32'h1234_5678, 32'h1234_5678, 1'b0,
         {1'b0, 1'b1, 1'b0, 32'd0});
`ifdef SKLANSKY_SUB_SAT_EN
    run1("ovf_neg", 32'h8000_0000, 32'd1, 1'b0,
         {1'b1, 1'b0, 1'b0, 32'h8000_0000});
    run1("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0,
         {1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF});
`else
    run1("ovf_neg", 32'h8000_0000, 32'd1, 1'b0,
         {1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF});
    run1("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0,
         {1'b1, 1'b0, 1'b1, 32'h8000_0000});
`endif

    // backpressure: fill both stages, then drain in order
    e0 = {1'b0, 1'b0, 1'b0, 32'd100};
    e1 = {1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE};
    e2 = {1'b0, 1'b1, 1'b0, 32'd0};
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 32'd150; b = 32'd50; bin = 1'b0;
    chk("bp_ir0", 64'(in_ready), 64'd1);
    tick();
    a = 32'd1; b = 32'd2; bin = 1'b1;
    chk("bp_ir1", 64'(in_ready), 64'd1);
    tick();
    a = 32'd77; b = 32'd76; bin = 1'b1;
    chk("bp_ir2", 64'(in_ready), 64'd0);
    chk("bp_ov", 64'(out_valid), 64'd1);
    chk("bp_y0", 64'(outs()), 64'(e0));
    hold = outs();
    tick();
    tick();
    chk("bp_hold_ir", 64'(in_ready), 64'd0);
    chk("bp_hold", 64'(outs()), 64'(hold));
    out_ready = 1'b1;
    #1;
    chk("bp_ir_comb", 64'(in_ready), 64'd1);
    chk("bp_r0", 64'(outs()), 64'(e0));
    tick();
    in_valid = 1'b0;
    chk("bp_v1", 64'(out_valid), 64'd1);
    chk("bp_r1", 64'(outs()), 64'(e1));
    tick();
    chk("bp_v2", 64'(out_valid), 64'd1);
    chk("bp_r2", 64'(outs()), 64'(e2));
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // throughput: back-to-back random transfers
    for (int k = 0; k < 102; k++) begin
      if (k < 100) begin
        ra = $urandom;
        rb = $urandom;
        rbin = 1'($urandom_range(1, 0));
        if (k % 10 == 0) rb = ra;
        in_valid = 1'b1;
        a = ra;
        b = rb;
        bin = rbin;
        q.push_back(model(ra, rb, rbin));
      end else begin
        in_valid = 1'b0;
      end
      if (k >= 2) begin
        chk("tp_vld", 64'(out_valid), 64'd1);
        if (q.size() > 0) chk("tp_res", 64'(outs()), 64'(q.pop_front()));
      end else begin
        chk("tp_lat", 64'(out_valid), 64'd0);
      end
      tick();
    end
    chk("tp_drain", 64'(out_valid), 64'd0);
    chk("tp_q", 64'(q.size()), 64'd0);

    // reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 32'd9; b = 32'd4; bin = 1'b0;
    tick();
    a = 32'd8; b = 32'd1; bin = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("mr_full", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_ov", 64'(out_valid), 64'd0);
    chk("mr_out", 64'(outs()), 64'd0);
    chk("mr_ir", 64'(in_ready), 64'd1);
    tick();
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mr_nostale0", 64'(out_valid), 64'd0);
    tick();
    chk("mr_nostale1", 64'(out_valid), 64'd0);
    run1("mr_new", 32'd3, 32'd1, 1'b1, {1'b0, 1'b0, 1'b0, 32'd1});
    chk("mr_end", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
